// File: rtl/pdm_tx_modulator.sv
// PCM-to-PDM transmitter: one-entry sample buffer, zero-order hold, second-order delta-sigma.
// One PDM bit per pdm_clk falling edge; pcm_ready drops while the buffer holds an unloaded sample.
module pdm_tx_modulator #(
  parameter int CLK_DIV     = 8,
  parameter int DECIM       = 64,
  parameter int INPUT_SHIFT = 1,
  parameter int ACC_W       = 24
) (
  input  logic               clk_25m,
  input  logic               rst_n,
  input  logic signed [15:0] pcm_sample,
  input  logic               pcm_valid,
  output logic               pcm_ready,
  output logic               pdm_clk,
  output logic               pdm_dat,
  output logic               sample_tick,
  output logic               underrun
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [SW-1:0] V_POS   = SW'(32768);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic                     pclk_q, pclk_d;
  logic                     full_q, full_d;
  logic signed [15:0]       buf_q, buf_d;
  logic signed [ACC_W-1:0]  x_q, x_d;
  logic signed [ACC_W-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic                     dat_q, dat_d;
  logic                     tick_q, tick_d;
  logic                     under_q, under_d;

  logic                     fall, load, accept;
  logic signed [ACC_W-1:0]  buf_ext, i1n, i2n;
  logic signed [SW-1:0]     vfb, i1_sum, i2_sum;

  function automatic logic signed [SW-1:0] ext(input logic signed [ACC_W-1:0] a);
    return {{2{a[ACC_W-1]}}, a};
  endfunction

  // Clamp rather than wrap so a hot input cannot flip an integrator's sign.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] a);
    if (a > SAT_MAX) return SAT_MAX[ACC_W-1:0];
    if (a < SAT_MIN) return SAT_MIN[ACC_W-1:0];
    return a[ACC_W-1:0];
  endfunction

  always_comb begin
    fall      = (cnt_q == CW'(CLK_DIV/2 - 1));
    load      = fall && (bit_q == '0);
    pcm_ready = !full_q || load;
    accept    = pcm_valid && pcm_ready;

    cnt_d  = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    pclk_d = (cnt_d < CW'(CLK_DIV/2));
    bit_d  = bit_q;
    if (fall) bit_d = (bit_q == BW'(DECIM - 1)) ? '0 : bit_q + 1'b1;

    buf_ext = {{(ACC_W-16){buf_q[15]}}, buf_q};
    x_d     = (load && full_q) ? (buf_ext >>> INPUT_SHIFT) : x_q;
    under_d = under_q | (load & !full_q);
    tick_d  = load;
    buf_d   = accept ? pcm_sample : buf_q;
    full_d  = accept ? 1'b1 : (load ? 1'b0 : full_q);

    // Modulator sees the freshly loaded x on a load edge.
    vfb    = dat_q ? V_POS : -V_POS;
    i1_sum = ext(i1_q) + ext(x_d) - vfb;
    i1n    = sat(i1_sum);
    i2_sum = ext(i2_q) + ext(i1n) - vfb;
    i2n    = sat(i2_sum);
    i1_d   = fall ? i1n : i1_q;
    i2_d   = fall ? i2n : i2_q;
    dat_d  = fall ? !i2n[ACC_W-1] : dat_q;
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      pclk_q  <= 1'b0;
      full_q  <= 1'b0;
      buf_q   <= '0;
      x_q     <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      dat_q   <= 1'b0;
      tick_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      pclk_q  <= pclk_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      x_q     <= x_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      dat_q   <= dat_d;
      tick_q  <= tick_d;
      under_q <= under_d;
    end
  end

  assign pdm_clk     = pclk_q;
  assign pdm_dat     = dat_q;
  assign sample_tick = tick_q;
  assign underrun    = under_q;

endmodule
